// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the two-port HD44780 character-LCD bus arbiter.
package lcd_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_EXEC  = 3'd4,
        S_DONE  = 3'd5
    } lcd_state_t;

    localparam logic PORT_INIT = 1'b0;
    localparam logic PORT_USER = 1'b1;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    // Clear (0x01) and both home encodings (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] code);
        return !rs && ((code == LCD_CMD_CLEAR) || ((code | 8'h01) == (LCD_CMD_HOME | 8'h01)));
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter that flags the last cycle of an LCD bus phase.
module lcd_cycle_timer
    import lcd_bus_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expired
);

    logic [W-1:0] count_reg;

    // Counts down to 1 and parks there; a phase of N cycles is loaded with N.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg > W'(1)) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign expired = (count_reg == W'(1));

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Two-port HD44780 bus controller: arbitrates init sequencer vs. runtime writer and
// generates setup/E-pulse/hold/exec timing. Define LCD_ARB_RR_EN for round-robin arbitration.
module lcd_bus_arbiter
    import lcd_bus_pkg::*;
#(
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_PULSE = 12,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_EXEC  = 2000,
    parameter int unsigned T_CLEAR = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_complete_flag,
    input  logic       req0,
    input  logic       rs0,
    input  logic       rw0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic       rs1,
    input  logic       rw1,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic [7:0] data
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_SETUP, T_PULSE), max_u(T_HOLD, T_EXEC)), T_CLEAR);
    localparam int TW = $clog2(T_MAX + 1);

    lcd_state_t state_reg, state_next;

    logic          e_reg, rs_reg, rw_reg;
    logic [7:0]    data_reg;
    logic          port_reg;
    logic          cooldown_reg;
    logic          grant;
    logic          pick_port;
    logic          timer_load;
    logic [TW-1:0] timer_value;
    logic          expired;

    lcd_cycle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (expired)
    );

`ifdef LCD_ARB_RR_EN
    logic last_grant_reg;

    // Resets to the user port so the init port wins the first contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= PORT_USER;
        end else if (grant) begin
            last_grant_reg <= pick_port;
        end
    end

    always_comb begin
        pick_port = req0 ? PORT_INIT : PORT_USER;
        if (req0 && req1 && init_complete_flag) begin
            pick_port = (last_grant_reg == PORT_INIT) ? PORT_USER : PORT_INIT;
        end
    end
`else
    always_comb begin
        pick_port = req0 ? PORT_INIT : PORT_USER;
    end
`endif

    always_comb begin
        state_next  = state_reg;
        grant       = 1'b0;
        timer_load  = 1'b0;
        timer_value = '0;
        unique case (state_reg)
            S_IDLE: begin
                // The IDLE cycle right after DONE skips arbitration, giving the
                // requester a cycle to drop its level request after ack.
                if (!cooldown_reg && (req0 || (req1 && init_complete_flag))) begin
                    grant       = 1'b1;
                    state_next  = S_SETUP;
                    timer_load  = 1'b1;
                    timer_value = TW'(T_SETUP);
                end
            end
            S_SETUP: begin
                if (expired) begin
                    state_next  = S_PULSE;
                    timer_load  = 1'b1;
                    timer_value = TW'(T_PULSE);
                end
            end
            S_PULSE: begin
                if (expired) begin
                    state_next  = S_HOLD;
                    timer_load  = 1'b1;
                    timer_value = TW'(T_HOLD);
                end
            end
            S_HOLD: begin
                if (expired) begin
                    state_next  = S_EXEC;
                    timer_load  = 1'b1;
                    timer_value = is_long_cmd(rs_reg, data_reg) ? TW'(T_CLEAR) : TW'(T_EXEC);
                end
            end
            S_EXEC: begin
                if (expired) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            e_reg        <= 1'b0;
            rs_reg       <= 1'b0;
            rw_reg       <= 1'b0;
            data_reg     <= 8'h00;
            port_reg     <= PORT_INIT;
            cooldown_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            e_reg        <= (state_next == S_PULSE);
            cooldown_reg <= (state_reg == S_DONE);
            // Requester fields are captured once at the grant; later changes are ignored.
            if (grant) begin
                port_reg <= pick_port;
                if (pick_port == PORT_INIT) begin
                    rs_reg   <= rs0;
                    rw_reg   <= rw0;
                    data_reg <= data0;
                end else begin
                    rs_reg   <= rs1;
                    rw_reg   <= rw1;
                    data_reg <= data1;
                end
            end
        end
    end

    assign ack0 = (state_reg == S_DONE) && (port_reg == PORT_INIT);
    assign ack1 = (state_reg == S_DONE) && (port_reg == PORT_USER);
    assign busy = (state_reg != S_IDLE);
    assign RS   = rs_reg;
    assign RW   = rw_reg;
    assign E    = e_reg;
    assign data = data_reg;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with shortened timing (2/4/2/10/40).
module tb_lcd_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst, flag;
    logic       req0, rs0, rw0, req1, rs1, rw1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, busy, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    lcd_bus_arbiter #(
        .T_SETUP(2), .T_PULSE(4), .T_HOLD(2), .T_EXEC(10), .T_CLEAR(40)
    ) dut (
        .clk(clk), .rst(rst), .init_complete_flag(flag),
        .req0(req0), .rs0(rs0), .rw0(rw0), .data0(data0),
        .req1(req1), .rs1(rs1), .rw1(rw1), .data1(data1),
        .ack0(ack0), .ack1(ack1), .busy(busy),
        .RS(lcd_rs), .RW(lcd_rw), .E(lcd_e), .data(lcd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;
    int ack0_at, ack1_at, ack0_n, ack1_n, e_first, e_last, e_cycles;
    int acks[$];
    bit auto_drop = 1'b1;
    int k;
    int exp_order[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        ack0_at = -1; ack1_at = -1; ack0_n = 0; ack1_n = 0;
        e_first = -1; e_last = -1; e_cycles = 0;
        acks.delete();
    endtask

    // One cycle: sample on the falling edge; cycle index of the sample is cyc+1.
    task automatic tick();
        @(negedge clk);
        if (ack0) begin
            ack0_at = cyc + 1; ack0_n++; acks.push_back(0);
            if (auto_drop) req0 = 1'b0;
        end
        if (ack1) begin
            ack1_at = cyc + 1; ack1_n++; acks.push_back(1);
            if (auto_drop) req1 = 1'b0;
        end
        if (lcd_e) begin
            if (e_first < 0) e_first = cyc + 1;
            e_last = cyc + 1;
            e_cycles++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; flag = 1'b0;
        req0 = 1'b0; rs0 = 1'b0; rw0 = 1'b0; data0 = 8'h00;
        req1 = 1'b0; rs1 = 1'b0; rw1 = 1'b0; data1 = 8'h00;
        clear_log();
        ticks(3);
        rst = 1'b0;
        ticks(2);
        check("rst_pins", {29'd0, lcd_e, lcd_rs, lcd_rw}, 32'd0);
        check("rst_data", {24'd0, lcd_data}, 32'd0);
        check("rst_ack_busy", {29'd0, ack0, ack1, busy}, 32'd0);

        // Data write 0x41 from port 0
        rs0 = 1'b1; rw0 = 1'b0; data0 = 8'h41; req0 = 1'b1;
        k = cyc + 1; clear_log();
        tick();
        check("a_rs", {31'd0, lcd_rs}, 32'd1);
        check("a_data", {24'd0, lcd_data}, 32'h41);
        check("a_busy", {31'd0, busy}, 32'd1);
        data0 = 8'h99; rs0 = 1'b0;
        ticks(30);
        check("a_e_first", e_first, k + 3);
        check("a_e_last", e_last, k + 6);
        check("a_e_cycles", e_cycles, 4);
        check("a_ack0_at", ack0_at, k + 19);
        check("a_ack_counts", {ack0_n[15:0], ack1_n[15:0]}, {16'd1, 16'd0});
        check("a_data_kept", {24'd0, lcd_data, 7'd0, lcd_rs} >> 0, {24'd0, 8'h41, 7'd0, 1'b1} >> 0);

        // Clear display takes the long wait
        rs0 = 1'b0; data0 = 8'h01; req0 = 1'b1;
        k = cyc + 1; clear_log();
        ticks(60);
        check("b_clear_ack", ack0_at, k + 49);

        // Home encoding 0x03
        data0 = 8'h03; req0 = 1'b1;
        k = cyc + 1; clear_log();
        ticks(60);
        check("b_home3_ack", ack0_at, k + 49);

        // 0x01 with RS=1 is data, short wait
        rs0 = 1'b1; data0 = 8'h01; req0 = 1'b1;
        k = cyc + 1; clear_log();
        ticks(30);
        check("b_data01_ack", ack0_at, k + 19);

        // Function set 0x38 as a read cycle: same timing, RW driven
        rs0 = 1'b0; rw0 = 1'b1; data0 = 8'h38; req0 = 1'b1;
        k = cyc + 1; clear_log();
        tick();
        check("b_rw", {31'd0, lcd_rw}, 32'd1);
        ticks(29);
        check("b_38_ack", ack0_at, k + 19);
        check("b_38_e_cycles", e_cycles, 4);
        rw0 = 1'b0;

        // Port 1 pending until init completes
        rs1 = 1'b1; data1 = 8'hFF; req1 = 1'b1;
        clear_log();
        ticks(100);
        check("c_no_e", e_cycles, 0);
        check("c_no_ack", {ack0_n[15:0], ack1_n[15:0]}, 32'd0);
        check("c_idle", {31'd0, busy}, 32'd0);
        flag = 1'b1;
        k = cyc + 1;
        ticks(25);
        check("c_ack1_at", ack1_at, k + 19);
        check("c_ack1_n", ack1_n, 1);
        check("c_data", {24'd0, lcd_data}, 32'hFF);

        // Simultaneous requests, requesters drop after ack
        rs0 = 1'b1; data0 = 8'h10; req0 = 1'b1;
        rs1 = 1'b1; data1 = 8'h20; req1 = 1'b1;
        k = cyc + 1; clear_log();
        ticks(50);
        check("d_ack0_at", ack0_at, k + 19);
        check("d_ack1_at", ack1_at, k + 40);
        check("d_order", {acks.size(), acks[0], acks[1]} , {32'd2, 32'd0, 32'd1});

        // Both held continuously across several transfers
`ifdef LCD_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        auto_drop = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        k = cyc + 1; clear_log();
        ticks(85);
        check("e_count", acks.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("e_grant%0d", i), acks[i], exp_order[i]);
        end
        req0 = 1'b0; req1 = 1'b0; auto_drop = 1'b1;
        ticks(30);
        check("e_idle", {31'd0, busy}, 32'd0);

        // Reset during the E pulse aborts the transfer
        rs0 = 1'b1; data0 = 8'h55; req0 = 1'b1;
        k = cyc + 1; clear_log();
        ticks(4);
        check("r_e_high", {31'd0, lcd_e}, 32'd1);
        rst = 1'b1; req0 = 1'b0;
        tick();
        check("r_e_low", {31'd0, lcd_e}, 32'd0);
        check("r_busy", {31'd0, busy}, 32'd0);
        check("r_pins", {23'd0, lcd_rs, lcd_data}, 32'd0);
        rst = 1'b0; clear_log();
        ticks(30);
        check("r_no_ack", {ack0_n[15:0], ack1_n[15:0]}, 32'd0);
        check("r_no_e", e_cycles, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
